// File: rtl/fetch_decode_reg_if.sv
// rtl/fetch_decode_reg_if.sv - Fetch-to-Decode instruction word interface
interface fetch_decode_reg_if #(
  parameter int N = 16
);
  // Instruction word offered by Fetch
  logic [N-1:0] IR_in;
  // Active-low load strobe: 0 loads IR_in, 1 stalls
  logic         write_en;
  // Registered instruction word presented to Decode
  logic [N-1:0] IR_out;

  // Fetch side: supplies the word and the stall control, observes the register
  modport master (
    output IR_in,
    output write_en,
    input  IR_out
  );

  // Register side: consumes the word and the stall control, drives Decode
  modport slave (
    input  IR_in,
    input  write_en,
    output IR_out
  );
endinterface

// File: rtl/fetch_decode_reg.sv
// rtl/fetch_decode_reg.sv - Fetch/Decode pipeline instruction register with stall and NOP reset
module fetch_decode_reg #(
  parameter int          N         = 16,
  parameter logic [31:0] NOP_VALUE = 32'd32
) (
  input  logic            clk,
  input  logic            reset,
  fetch_decode_reg_if.slave fd
);

  // NOP encoding fitted to the word width: zero-extended above 32 bits, truncated below.
  // N must be at least 6 so that bit 5 of the default NOP survives.
  localparam logic [N-1:0] NOP_WORD = N'(NOP_VALUE);

  logic [N-1:0] ir_q;

  // Instruction register: asynchronous reset injects a NOP; otherwise load when write_en is low, hold when high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q <= NOP_WORD;
    end else if (!fd.write_en) begin
      ir_q <= fd.IR_in;
    end
  end

  // Decode sees the register directly; there is no bypass from IR_in
  assign fd.IR_out = ir_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb/tb_fetch_decode_reg.sv - Self-checking bench for the Fetch/Decode instruction register
module tb_fetch_decode_reg;

  localparam int          N   = 16;
  localparam logic [N-1:0] NOP = 16'h0020;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_decode_reg_if #(.N(N)) fd_if ();

  fetch_decode_reg #(.N(N), .NOP_VALUE(32'd32)) dut (
    .clk   (clk),
    .reset (reset),
    .fd    (fd_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural value of the instruction register as Decode should see it
  logic [N-1:0] model;

  // Advance one clock: the word in force at the edge is NOP under reset, IR_in when loading, unchanged when stalled
  task automatic tick();
    if (!reset) model = NOP;
    else if (!fd_if.write_en) model = fd_if.IR_in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fd_if.write_en = 1'b0;
    fd_if.IR_in    = 16'd10;
    #1;
    reset = 1'b0;
    model = NOP;
    #1;
    n_cmp++;
    if (fd_if.IR_out !== 16'd32) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", fd_if.IR_out, 16'd32);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (fd_if.IR_out !== 16'd32) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, fd_if.IR_out, 16'd32);
      end
    end
  endtask

  task automatic test_load();
    reset          = 1'b1;
    fd_if.write_en = 1'b0;
    fd_if.IR_in    = 16'd10;
    #1;
    n_cmp++;
    if (fd_if.IR_out !== 16'd32) begin
      n_fail++;
      $display("FAIL release_no_edge: got %h expected %h", fd_if.IR_out, 16'd32);
    end
    tick();
    n_cmp++;
    if (fd_if.IR_out !== 16'd10) begin
      n_fail++;
      $display("FAIL load: got %h expected %h", fd_if.IR_out, 16'd10);
    end
  endtask

  task automatic test_stall();
    fd_if.write_en = 1'b1;
    fd_if.IR_in    = 16'd100;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (fd_if.IR_out !== 16'd10) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h expected %h", i, fd_if.IR_out, 16'd10);
      end
    end
  endtask

  task automatic test_resume();
    fd_if.write_en = 1'b0;
    fd_if.IR_in    = 16'd100;
    tick();
    n_cmp++;
    if (fd_if.IR_out !== 16'd100) begin
      n_fail++;
      $display("FAIL resume: got %h expected %h", fd_if.IR_out, 16'd100);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b0;
    model = NOP;
    #1;
    n_cmp++;
    if (fd_if.IR_out !== 16'd32) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", fd_if.IR_out, 16'd32);
    end
    fd_if.IR_in = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (fd_if.IR_out !== 16'd32) begin
        n_fail++;
        $display("FAIL reset_mid_hold[%0d]: got %h expected %h", i, fd_if.IR_out, 16'd32);
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (fd_if.IR_out !== 16'd32) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %h expected %h", fd_if.IR_out, 16'd32);
    end
  endtask

  task automatic test_back_to_back();
    fd_if.write_en = 1'b0;
    fd_if.IR_in    = 16'hFFFF;
    tick();
    n_cmp++;
    if (fd_if.IR_out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", fd_if.IR_out, 16'hFFFF);
    end
    fd_if.IR_in = 16'h0001;
    tick();
    n_cmp++;
    if (fd_if.IR_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL b2b_second: got %h expected %h", fd_if.IR_out, 16'h0001);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        // Short reset pulse entirely between two edges
        #2;
        reset = 1'b0;
        model = NOP;
        #1;
        n_cmp++;
        if (fd_if.IR_out !== model) begin
          n_fail++;
          $display("FAIL rand_reset[%0d]: got %h expected %h", i, fd_if.IR_out, model);
        end
        #1;
        reset = 1'b1;
      end else begin
        fd_if.write_en = 1'($urandom_range(0, 1));
        fd_if.IR_in    = N'($urandom);
        tick();
        n_cmp++;
        if (fd_if.IR_out !== model) begin
          n_fail++;
          $display("FAIL rand_step[%0d]: got %h expected %h (we=%b in=%h)",
                   i, fd_if.IR_out, model, fd_if.write_en, fd_if.IR_in);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_resume();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
